// File: rtl/sap_output_display.sv
// sap_output_display
//
// Takes the 8-bit SAP output-register value and drives a 4-digit multiplexed
// 7-segment display. A new value is converted to BCD by a sequential
// double-dabble engine. The engine starts only when the input differs from
// the last value it converted. The four digits are scanned by a refresh
// divider.
//
// Optional feature: define SAP_DISPLAY_SIGNED_EN to treat out_data as two's
// complement. In that build the magnitude is converted and digit 3 shows a
// minus sign for negative values. Without it, values are unsigned 0..255 and
// digit 3 is always blank.
//
// Parameters
//   REFRESH_DIV  clk cycles each digit stays lit (1..65535)
//   LZ_BLANK     1 = blank leading zeros in hundreds/tens, 0 = show all digits
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   out_data   in   [7:0]  value from the output register
//   bcd        out  [11:0] {hundreds,tens,ones} of the last completed conversion
//   bcd_valid  out  one-cycle pulse when bcd updates
//   busy       out  high while a conversion is in progress
//   an         out  [3:0]  digit enables, active-low one-hot (0=ones .. 3=sign)
//   seg        out  [6:0]  segments {g,f,e,d,c,b,a}, active-low

module sap_output_display #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  out_data,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam logic [15:0] REFRESH_TERM = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_BLANK    = 7'b1111111;
    localparam logic [6:0]  SEG_MINUS    = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] sr_q, sr_d;
    logic [2:0]  iter_q, iter_d;
    logic [7:0]  last_q, last_d;
    logic [11:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        neg_pend_q, neg_pend_d;
    logic        sign_q, sign_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    logic [7:0]  conv_mag;
    logic        conv_neg;

    // One double-dabble iteration: correct each BCD nibble that would
    // overflow past 9 when doubled, then shift the whole register left.
    function automatic logic [19:0] dabble_step(input logic [19:0] r);
        logic [19:0] a;
        a = r;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // Converter input: the magnitude in the signed build (8'h80 -> 128 still
    // fits in 8 bits), or the raw value otherwise.
`ifdef SAP_DISPLAY_SIGNED_EN
    logic signed [8:0] sval;
    always_comb begin
        sval     = $signed({out_data[7], out_data});
        conv_neg = out_data[7];
        conv_mag = out_data[7] ? 8'(-sval) : out_data;
    end
`else
    always_comb begin
        conv_neg = 1'b0;
        conv_mag = out_data;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            iter_q     <= '0;
            last_q     <= '0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            neg_pend_q <= 1'b0;
            sign_q     <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            an_q       <= 4'hF;
            seg_q      <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            iter_q     <= iter_d;
            last_q     <= last_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            neg_pend_q <= neg_pend_d;
            sign_q     <= sign_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (out_data != last_q) state_d = SHIFT;
            SHIFT:   if (iter_q == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Conversion datapath and registered outputs
    always_comb begin
        sr_d       = sr_q;
        iter_d     = iter_q;
        last_d     = last_q;
        bcd_d      = bcd_q;
        valid_d    = 1'b0;
        neg_pend_d = neg_pend_q;
        sign_d     = sign_q;

        case (state_q)
            IDLE: begin
                if (out_data != last_q) begin
                    sr_d       = {12'h000, conv_mag};
                    last_d     = out_data;
                    iter_d     = '0;
                    neg_pend_d = conv_neg;
                end
            end
            SHIFT: begin
                sr_d   = dabble_step(sr_q);
                iter_d = iter_q + 3'd1;
            end
            DONE: begin
                bcd_d   = sr_q[19:8];
                valid_d = 1'b1;
                sign_d  = neg_pend_q;
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Digit scan: the digit is chosen from the index before it advances,
    // so the first cycle after reset shows digit 0.
    always_comb begin
        if (cnt_q == REFRESH_TERM) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 16'd1;
            idx_d = idx_q;
        end

        an_d = ~(4'b0001 << idx_q);

        case (idx_q)
            2'd0: seg_d = seg_pattern(bcd_q[3:0]);
            2'd1: begin
                if (LZ_BLANK && bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0)
                    seg_d = SEG_BLANK;
                else
                    seg_d = seg_pattern(bcd_q[7:4]);
            end
            2'd2: begin
                if (LZ_BLANK && bcd_q[11:8] == 4'd0)
                    seg_d = SEG_BLANK;
                else
                    seg_d = seg_pattern(bcd_q[11:8]);
            end
            default: seg_d = sign_q ? SEG_MINUS : SEG_BLANK;
        endcase
    end

    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;
    assign busy      = busy_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_sap_output_display.sv
module tb_sap_output_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  out_data = 8'h00;
    logic [11:0] bcd, bcd2;
    logic        bcd_valid, bcd_valid2;
    logic        busy, busy2;
    logic [3:0]  an, an2;
    logic [6:0]  seg, seg2;

    sap_output_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .reset(reset), .out_data(out_data),
        .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy), .an(an), .seg(seg)
    );

    sap_output_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut_nolz (
        .clk(clk), .reset(reset), .out_data(out_data),
        .bcd(bcd2), .bcd_valid(bcd_valid2), .busy(busy2), .an(an2), .seg(seg2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [6:0] pat [10];
    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;
    end

    int         m_last, m_rem, m_val, p_val, m_idx, m_cnt;
    bit         m_neg, p_neg, m_valid, m_busy;
    logic [3:0] m_an;
    logic [6:0] m_seg, m_seg2;

    function automatic logic [6:0] shown(input int idx, input int v, input bit neg, input bit lz);
        int h, t, o;
        h = v / 100; t = (v / 10) % 10; o = v % 10;
        case (idx)
            0: return pat[o];
            1: return (lz && h == 0 && t == 0) ? 7'h7F : pat[t];
            2: return (lz && h == 0) ? 7'h7F : pat[h];
            default: return neg ? 7'b0111111 : 7'h7F;
        endcase
    endfunction

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_last = 0; m_rem = 0; m_val = 0; p_val = 0; m_idx = 0; m_cnt = 0;
            m_neg = 0; p_neg = 0; m_valid = 0; m_busy = 0;
            m_an = 4'hF; m_seg = 7'h7F; m_seg2 = 7'h7F;
        end else begin
            m_an   = 4'hF & ~(4'h1 << m_idx);
            m_seg  = shown(m_idx, m_val, m_neg, 1'b1);
            m_seg2 = shown(m_idx, m_val, m_neg, 1'b0);
            m_cnt++;
            if (m_cnt == DIV) begin m_cnt = 0; m_idx = (m_idx + 1) % 4; end
            m_valid = 0;
            if (m_rem == 0) begin
                if (int'(out_data) != m_last) begin
                    m_last = out_data;
`ifdef SAP_DISPLAY_SIGNED_EN
                    p_neg = out_data[7];
                    p_val = out_data[7] ? 256 - int'(out_data) : int'(out_data);
`else
                    p_neg = 0;
                    p_val = out_data;
`endif
                    m_rem = 9;  // 8 shift cycles plus the completion cycle
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_val = p_val; m_neg = p_neg; m_valid = 1;
                end
            end
            m_busy = (m_rem != 0);
        end
    end

    // ---------------- compare process ----------------
    bit         started = 0;
    int         pulse_cnt = 0, busy_cnt = 0, first_pulse_bcd = -1;
    logic [6:0] seen [4];
    logic [6:0] seen2 [4];

    always @(negedge clk) begin
        if (started && !reset) begin
            chk("bcd", bcd, to_bcd(m_val));
            chk("bcd_valid", bcd_valid, m_valid);
            chk("busy", busy, m_busy);
            chk("an", an, m_an);
            chk("seg", seg, m_seg);
            chk("an_nolz", an2, m_an);
            chk("seg_nolz", seg2, m_seg2);
            if (bcd_valid) begin
                if (pulse_cnt == 0) first_pulse_bcd = bcd;
                pulse_cnt++;
            end
            if (busy) busy_cnt++;
            for (int i = 0; i < 4; i++) begin
                if (an == (4'hF & ~(4'h1 << i))) seen[i] = seg;
                if (an2 == (4'hF & ~(4'h1 << i))) seen2[i] = seg2;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        pulse_cnt = 0; busy_cnt = 0; first_pulse_bcd = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 reset = 1'b1;
        step(); step();
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_bcd", bcd, 12'h000);
        chk("reset_busy", busy, 0);
        chk("reset_valid", bcd_valid, 0);

        reset = 1'b0;
        started = 1;
        clear_counts();
        step();
        chk("release_an", an, 4'hE);
        chk("release_seg", seg, 7'b1000000);
        repeat (12) step();
        chk("release_no_pulse", pulse_cnt, 0);

        // Two back-to-back values: the second arrives mid-conversion
        clear_counts();
        out_data = 8'h10;
        repeat (3) step();
        out_data = 8'h63;
        repeat (30) step();
        chk("two_pulses", pulse_cnt, 2);
        chk("first_pulse_bcd", first_pulse_bcd, 12'h016);
        chk("second_bcd", bcd, 12'h099);

`ifdef SAP_DISPLAY_SIGNED_EN
        out_data = 8'h80;
        repeat (30) step();
        chk("s80_bcd", bcd, 12'h128);
        chk("s80_sign", seen[3], 7'b0111111);
        out_data = 8'hFF;
        repeat (30) step();
        chk("sFF_bcd", bcd, 12'h001);
        chk("sFF_sign", seen[3], 7'b0111111);
        out_data = 8'h7F;
        repeat (30) step();
        chk("s7F_bcd", bcd, 12'h127);
        chk("s7F_sign", seen[3], 7'h7F);
`else
        // 0xFF: latency and scan contents
        clear_counts();
        out_data = 8'hFF;
        repeat (12) step();
        chk("ff_busy_cycles", busy_cnt, 9);
        chk("ff_pulses", pulse_cnt, 1);
        chk("ff_bcd", bcd, 12'h255);
        repeat (20) step();
        chk("ff_digit0", seen[0], 7'b0010010);
        chk("ff_digit1", seen[1], 7'b0010010);
        chk("ff_digit2", seen[2], 7'b0100100);
        chk("ff_digit3", seen[3], 7'h7F);

        // 0x07: leading-zero blanking on one instance, not the other
        out_data = 8'h07;
        repeat (32) step();
        chk("07_bcd", bcd, 12'h007);
        chk("07_ones", seen[0], 7'b1111000);
        chk("07_tens_blank", seen[1], 7'h7F);
        chk("07_hund_blank", seen[2], 7'h7F);
        chk("07_nolz_ones", seen2[0], 7'b1111000);
        chk("07_nolz_tens", seen2[1], 7'b1000000);
        chk("07_nolz_hund", seen2[2], 7'b1000000);

        // Reset during a conversion
        clear_counts();
        out_data = 8'hC8;
        repeat (5) step();
        reset = 1'b1;
        step(); step();
        chk("abort_bcd", bcd, 12'h000);
        chk("abort_busy", busy, 0);
        chk("abort_an", an, 4'hF);
        reset = 1'b0;
        repeat (14) step();
        chk("abort_pulses", pulse_cnt, 1);
        chk("restart_bcd", bcd, 12'h200);
`endif

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 300; n++) begin
            out_data = 8'($urandom);
            repeat ($urandom_range(1, 14)) step();
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
        end
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
